// File: rtl/uart_rx_framer_pkg.sv
// uart_rx_pkg: shared state encoding and synchronizer reset level for uart_rx_framer.
package uart_rx_pkg;
   typedef enum logic [2:0] {IDLE, START_CHK, RX_BITS, PARITY_CHK, STOP_CHK, LOAD} rx_state_t;
   localparam logic SYNC_RST_VAL = 1'b1;
endpackage

// File: rtl/uart_rx_framer_if.sv
// uart_rx_framer_if: serial line, consumer handshake and status of the framer.
// UART_RX_PARITY_EN adds parity_error.
interface uart_rx_framer_if #(parameter int DATA_BITS = 8);
   logic                 serial_in;
   logic                 data_read;
   logic [DATA_BITS-1:0] rx_data;
   logic                 data_ready;
   logic                 overrun_error;
   logic                 framing_error;
   logic                 busy;
`ifdef UART_RX_PARITY_EN
   logic                 parity_error;
`endif
   modport slave (
      input  serial_in, data_read,
`ifdef UART_RX_PARITY_EN
      output parity_error,
`endif
      output rx_data, data_ready, overrun_error, framing_error, busy
   );
   modport master (
      output serial_in, data_read,
`ifdef UART_RX_PARITY_EN
      input  parity_error,
`endif
      input  rx_data, data_ready, overrun_error, framing_error, busy
   );
endinterface

// File: rtl/uart_rx_framer_timer.sv
// rx_bit_timer: clearable counter running 1..i_max with a one-cycle strobe at rollover.
module rx_bit_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic [W-1:0] i_max,
   output logic         o_tick
);
   logic [W-1:0] r_cnt;
   logic [W-1:0] w_inc;
   assign w_inc  = r_cnt + 1'b1;
   assign o_tick = i_en & (w_inc == i_max);
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en) r_cnt <= o_tick ? '0 : w_inc;
endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: start detect, bit timing, LSB-first shift and stop check into a holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_error output.
module uart_rx_framer
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_BITS    = 8
) (
   input logic             clk,
   input logic             n_rst,
   uart_rx_framer_if.slave bus
);
   localparam int TW = $clog2(CLKS_PER_BIT + 1);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [2:0] S_IDLE  = IDLE;
   localparam logic [2:0] S_START = START_CHK;
   localparam logic [2:0] S_BITS  = RX_BITS;
   localparam logic [2:0] S_STOP  = STOP_CHK;
   localparam logic [2:0] S_LOAD  = LOAD;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PAR   = PARITY_CHK;
   logic r_par, r_perr, w_perr;
`endif
   logic [2:0]           r_state, w_next;
   logic                 r_sync1, r_sync2, r_prev;
   logic                 r_stop, r_ready, r_ovr, r_ferr;
   logic [DATA_BITS-1:0] r_shift, r_data;
   logic                 w_fall, w_clr, w_tick, w_bits_done, w_good;
   logic [TW-1:0]        w_period;
   assign w_fall   = r_prev & ~r_sync2;
   assign w_clr    = (w_next != r_state);
   assign w_period = (r_state == S_START) ? TW'(CLKS_PER_BIT / 2) : TW'(CLKS_PER_BIT);
   rx_bit_timer #(.W(TW)) u_period (
      .clk, .n_rst, .i_clr(w_clr), .i_en(r_state != S_IDLE),
      .i_max(w_period), .o_tick(w_tick)
   );
   rx_bit_timer #(.W(BW)) u_bitcnt (
      .clk, .n_rst, .i_clr(w_clr), .i_en(w_tick && r_state == S_BITS),
      .i_max(BW'(DATA_BITS)), .o_tick(w_bits_done)
   );
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_fall ? S_START : S_IDLE;
         S_START: w_next = !w_tick ? S_START : (r_sync2 ? S_IDLE : S_BITS);
`ifdef UART_RX_PARITY_EN
         S_BITS:  w_next = w_bits_done ? S_PAR : S_BITS;
         S_PAR:   w_next = w_tick ? S_STOP : S_PAR;
`else
         S_BITS:  w_next = w_bits_done ? S_STOP : S_BITS;
`endif
         S_STOP:  w_next = w_tick ? S_LOAD : S_STOP;
         default: w_next = S_IDLE;
      endcase
   end
`ifdef UART_RX_PARITY_EN
   assign w_perr = ^{r_shift, r_par};
   assign w_good = r_stop & ~w_perr;
   assign bus.parity_error = r_perr;
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         r_par  <= 1'b0;
         r_perr <= 1'b0;
      end else begin
         if (r_state == S_PAR && w_tick) r_par <= r_sync2;
         if (r_state == S_LOAD) r_perr <= w_perr;
      end
`else
   assign w_good = r_stop;
`endif
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) {r_sync1, r_sync2, r_prev} <= {3{SYNC_RST_VAL}};
      else {r_sync1, r_sync2, r_prev} <= {bus.serial_in, r_sync1, r_sync2};
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_stop  <= 1'b0;
         r_data  <= '0;
         r_ready <= 1'b0;
         r_ovr   <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_BITS && w_tick) r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
         if (r_state == S_STOP && w_tick) r_stop <= r_sync2;
         if (r_state == S_LOAD) begin
            r_ferr <= ~r_stop;
            if (w_good) begin
               r_data  <= r_shift;
               r_ready <= 1'b1;
               r_ovr   <= r_ready & ~bus.data_read;
            end
         end else if (bus.data_read) begin
            r_ready <= 1'b0;
            r_ovr   <= 1'b0;
         end
      end
   assign bus.rx_data       = r_data;
   assign bus.data_ready    = r_ready;
   assign bus.overrun_error = r_ovr;
   assign bus.framing_error = r_ferr;
   assign bus.busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: directed and random frames checked against a frame-level model of the holding register.
module tb_uart_rx_framer;
   logic clk = 1'b0;
   logic n_rst = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;
   logic [7:0] m_data = 8'h00;
   logic       m_ready = 1'b0;
   logic       m_ovr = 1'b0;
   logic       m_ferr = 1'b0;

   uart_rx_framer_if #(.DATA_BITS(8)) bus();
   uart_rx_framer #(.CLKS_PER_BIT(10), .DATA_BITS(8)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic busy_exp);
      chk({tag, " rx_data"}, {1'b0, bus.rx_data}, {1'b0, m_data});
      chk({tag, " data_ready"}, {8'h00, bus.data_ready}, {8'h00, m_ready});
      chk({tag, " overrun"}, {8'h00, bus.overrun_error}, {8'h00, m_ovr});
      chk({tag, " framing"}, {8'h00, bus.framing_error}, {8'h00, m_ferr});
      chk({tag, " busy"}, {8'h00, bus.busy}, {8'h00, busy_exp});
   endtask

   // Frame-level rules: a good stop loads the word; a bad stop only flags framing.
   task automatic model_frame(input logic [7:0] d, input logic stop, input logic rd);
      if (stop) begin
         m_ovr   = m_ready & ~rd;
         m_data  = d;
         m_ready = 1'b1;
         m_ferr  = 1'b0;
      end else m_ferr = 1'b1;
   endtask

   task automatic model_reset();
      m_data = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
   endtask

   // Drives one 100-cycle frame starting at a negedge; the next posedge is T0.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int abort_at,
                             input logic chk_lat, input logic rd_load);
      logic [9:0] bits;
      logic       pre_ready;
      logic [7:0] pre_data;
      bits = {stop, d, 1'b0};
      pre_ready = m_ready;
      pre_data = m_data;
      for (int i = 0; i < 100; i++) begin
         bus.serial_in = bits[0];
         bus.data_read = rd_load && (i == 98);
         if (i == abort_at) begin
            n_rst = 1'b0;
            bus.serial_in = 1'b1;
            #1;
            model_reset();
            check_state("abort", 1'b0);
            @(negedge clk);
            n_rst = 1'b1;
            repeat (2) @(negedge clk);
            return;
         end
         @(negedge clk);
         if (i % 10 == 9) bits = bits >> 1;
         if (i == 50) chk("mid-frame busy", {8'h00, bus.busy}, 9'h1);
         if (chk_lat && i == 97) begin
            chk("T0+97 data_ready", {8'h00, bus.data_ready}, {8'h00, pre_ready});
            chk("T0+97 rx_data", {1'b0, bus.rx_data}, {1'b0, pre_data});
         end
         if (chk_lat && i == 98)
            chk("T0+98 data_ready", {8'h00, bus.data_ready}, {8'h00, stop | pre_ready});
      end
      bus.data_read = 1'b0;
      bus.serial_in = 1'b1;
      model_frame(d, stop, rd_load);
      repeat (2) @(negedge clk);
      check_state("frame", 1'b0);
   endtask

   task automatic pulse_read();
      bus.data_read = 1'b1;
      @(negedge clk);
      bus.data_read = 1'b0;
      m_ready = 1'b0;
      m_ovr = 1'b0;
      check_state("read", 1'b0);
   endtask

   initial begin
      logic [7:0] rd;
      logic       rs, rl;
      bus.serial_in = 1'b1;
      bus.data_read = 1'b0;
      #2 n_rst = 1'b0;
      #1 check_state("reset", 1'b0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle busy", {8'h00, bus.busy}, 9'h0);
      end
      send_frame(8'hA5, 1'b1, -1, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b0, -1, 1'b1, 1'b0);
      send_frame(8'h11, 1'b1, -1, 1'b1, 1'b0);
      pulse_read();
      send_frame(8'h12, 1'b1, -1, 1'b0, 1'b0);
      send_frame(8'h34, 1'b1, -1, 1'b0, 1'b0);
      chk("overrun set", {8'h00, bus.overrun_error}, 9'h1);
      pulse_read();
      pulse_read();
      // Short low pulse: must be rejected at the mid-bit check.
      bus.serial_in = 1'b0;
      repeat (3) @(negedge clk);
      bus.serial_in = 1'b1;
      @(negedge clk);
      chk("glitch busy", {8'h00, bus.busy}, 9'h1);
      repeat (5) @(negedge clk);
      check_state("glitch", 1'b0);
      send_frame(8'h5A, 1'b1, 52, 1'b0, 1'b0);
      send_frame(8'hC3, 1'b1, -1, 1'b1, 1'b0);
      send_frame(8'h77, 1'b1, -1, 1'b1, 1'b1);
      send_frame(8'h0F, 1'b0, -1, 1'b1, 1'b1);
      for (int k = 0; k < 12; k++) begin
         rd = 8'($urandom);
         rs = ($urandom_range(0, 3) != 0);
         rl = 1'($urandom_range(0, 1));
         send_frame(rd, rs, -1, 1'b1, rl);
         if ($urandom_range(0, 2) == 0) pulse_read();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
